// File: rtl/mcu_pkg.sv
// mcu_pkg: shared opcodes, instruction field positions, FSM states and ALU
// operation encoding for the mcu_core_pm multicycle core.
package mcu_pkg;

  // Opcodes (instruction bits [15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Low bit of each 4-bit field; imm4 shares rt, imm8 is [7:0], imm12 is [11:0]
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MUL
  } alu_op_e;

endpackage

// File: rtl/mcu_core_pm_if.sv
// mcu_core_pm_if: single shared memory port with req/ready handshake.
// The core is the master; the memory model is the slave.
interface mcu_core_pm_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/mcu_alu.sv
// mcu_alu: combinational datapath ALU plus equality compare for BEQ.
// The multiplier only exists when CPU_MUL_EN is defined.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              eq
);

  assign eq = (a == b);

  // Result select; all arithmetic wraps modulo 2^DATA_W
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
`ifdef CPU_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mcu_core_pm.sv
// mcu_core_pm: non-pipelined multicycle 16-bit-ISA core with a parametrised
// datapath. FETCH -> EXEC -> (MEM) -> FETCH; HALT is terminal until reset.
// Optional feature macro: CPU_MUL_EN (opcode B = unsigned multiply).
module mcu_core_pm
  import mcu_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  mcu_core_pm_if.master       bus,
  output logic                halted,
  output logic                illegal
);

  state_e                  state;
  logic [ADDR_W-1:0]       pc;
  logic [15:0]             ir;
  logic [15:0][DATA_W-1:0] rf;

  logic [3:0]        op, rd, rs, rt;
  logic [DATA_W-1:0] rd_val, rs_val, rt_val, imm4_x;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_eq;
  alu_op_e           alu_op;
  logic              rf_wen;
  logic [DATA_W-1:0] rf_wd;
  logic [ADDR_W-1:0] br_off;

  assign op     = ir[OP_LSB +: 4];
  assign rd     = ir[RD_LSB +: 4];
  assign rs     = ir[RS_LSB +: 4];
  assign rt     = ir[RT_LSB +: 4];
  // r0 is never written, so it always reads as zero
  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign rt_val = rf[rt];
  assign imm4_x = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign br_off = {{(ADDR_W-4){ir[3]}}, ir[3:0]};

  // Operand and operation select; BEQ reuses the ALU comparator on rd/rs
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = rs_val;
    alu_b  = rt_val;
    case (op)
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_MUL:  alu_op = ALU_MUL;
      OP_ADDI: alu_b  = imm4_x;
      OP_BEQ: begin
        alu_a = rd_val;
        alu_b = rs_val;
      end
      default: ;
    endcase
  end

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y),
    .eq (alu_eq)
  );

  // Register write-back: ALU/LDI in EXEC, LD only on the completing MEM cycle
  always_comb begin
    rf_wen = 1'b0;
    rf_wd  = alu_y;
    if (state == EXEC) begin
      case (op)
`ifdef CPU_MUL_EN
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_MUL: rf_wen = 1'b1;
`else
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI:         rf_wen = 1'b1;
`endif
        OP_LDI: begin
          rf_wen = 1'b1;
          rf_wd  = DATA_W'(ir[7:0]);
        end
        default: ;
      endcase
    end else if (state == MEM && op == OP_LD && bus.mem_req && bus.mem_ready) begin
      rf_wen = 1'b1;
      rf_wd  = bus.mem_rdata;
    end
  end

  // Control FSM with registered memory-port outputs. Every access state
  // spends its first cycle with mem_req low, which guarantees a gap between
  // accesses and lets the address settle before the request is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      ir            <= '0;
      rf            <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      if (rf_wen && rd != 4'd0) rf[rd] <= rf_wd;
      case (state)
        FETCH: begin
          if (!bus.mem_req) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= pc;
          end else if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            ir          <= bus.mem_rdata[15:0];
            pc          <= pc + ADDR_W'(1);
            state       <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          case (op)
`ifdef CPU_MUL_EN
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI, OP_MUL: ;
`else
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI: ;
`endif
            OP_LD, OP_ST: state <= MEM;
            OP_BEQ:  if (alu_eq) pc <= pc + br_off;
            OP_JMP:  pc <= ADDR_W'(ir[11:0]);
            OP_HALT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            default: illegal <= 1'b1;
          endcase
        end
        MEM: begin
          if (!bus.mem_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (op == OP_ST);
            bus.mem_addr  <= ADDR_W'(rs_val);
            bus.mem_wdata <= rd_val;
          end else if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_core_pm.sv
// tb_mcu_core_pm: program-driven bench. Results leave the core through ST
// instructions; expected stores are queued before each run and matched in
// order against the stores observed on the memory port.
`timescale 1ns/1ps
module tb_mcu_core_pm;
  import mcu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted, illegal;

  always #5 clk = ~clk;

  mcu_core_pm_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mcu_core_pm #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .halted  (halted),
    .illegal (illegal)
  );

  // Memory model: program image plus a data overlay written by stores
  logic [15:0]   prog [256];
  logic [DW-1:0] dmem [256];
  logic          dval [256];
  int            stall_n = 0;
  int            scnt = 0;
  int            proto_err = 0;

  typedef struct packed { logic [7:0] addr; logic [DW-1:0] data; } st_t;
  st_t sb[$];
  st_t obs[$];

  assign bus.mem_ready = (scnt >= stall_n);
  assign bus.mem_rdata = dval[bus.mem_addr[7:0]] ? dmem[bus.mem_addr[7:0]]
                                                 : DW'(prog[bus.mem_addr[7:0]]);

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ready) scnt <= 0;
    else                               scnt <= scnt + 1;
  end

  logic          p_req, p_rdy, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) dval[i] <= 1'b0;
      p_req <= 1'b0;
      p_rdy <= 1'b0;
    end else begin
      if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
        dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        dval[bus.mem_addr[7:0]] <= 1'b1;
        obs.push_back({bus.mem_addr[7:0], bus.mem_wdata});
      end
      // programs live below 0x20, so a write there is a write during fetch
      if (bus.mem_req && bus.mem_we && bus.mem_addr < 16'h20) proto_err <= proto_err + 1;
      if (p_req && p_rdy && bus.mem_req) proto_err <= proto_err + 1;
      if (p_req && !p_rdy && (!bus.mem_req || bus.mem_addr != p_addr ||
                              bus.mem_we != p_we || bus.mem_wdata != p_wd))
        proto_err <= proto_err + 1;
      p_req  <= bus.mem_req;
      p_rdy  <= bus.mem_ready;
      p_we   <= bus.mem_we;
      p_addr <= bus.mem_addr;
      p_wd   <= bus.mem_wdata;
    end
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
  endtask

  // Reset, release on a falling edge, count rising edges until halted
  task automatic run(input int stall, input int maxc, output int cyc);
    stall_n = stall;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs.delete();
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < maxc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (halted) break;
    end
  endtask

  task automatic compare_stores(input string name);
    st_t e, a;
    check({name, " store count"}, 32'(obs.size()), 32'(sb.size()));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      a = obs.pop_front();
      check({name, " store"}, 32'(a), 32'(e));
    end
    sb.delete();
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] exp;
    logic       ill;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   cyc;
    bit   found;

    vt[0] = '{"add",  OP_ADD,  8'd5,   8'd7,   16'd12,     1'b0};
    vt[1] = '{"sub",  OP_SUB,  8'd0,   8'd1,   16'hFFFF,   1'b0};
    vt[2] = '{"and",  OP_AND,  8'hF0,  8'h3C,  16'h0030,   1'b0};
    vt[3] = '{"or",   OP_OR,   8'hF0,  8'h0C,  16'h00FC,   1'b0};
    vt[4] = '{"xor",  OP_XOR,  8'hFF,  8'h0F,  16'h00F0,   1'b0};
    vt[5] = '{"addi", OP_ADDI, 8'd5,   8'h0E,  16'd3,      1'b0};
`ifdef CPU_MUL_EN
    vt[6] = '{"mul",  OP_MUL,  8'd3,   8'd4,   16'd12,     1'b0};
`else
    vt[6] = '{"mul",  OP_MUL,  8'd3,   8'd4,   16'd0,      1'b1};
`endif

    // Reset state
    clear_prog();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_req",   32'(bus.mem_req),   32'd0);
    check("rst mem_we",    32'(bus.mem_we),    32'd0);
    check("rst mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst halted",    32'(halted),        32'd0);
    check("rst illegal",   32'(illegal),       32'd0);

    // LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT -> halted on cycle 12
    clear_prog();
    prog[0] = 16'h6105; prog[1] = 16'h6207; prog[2] = 16'h0312;
    run(0, 100, cyc);
    check("halt cycle", 32'(cyc), 32'd12);
    check("halt flag",  32'(halted), 32'd1);

    // ALU table: LDI r1,a; LDI r2,b; op r3; LDI r4,0x80; ST r3,[r4]; HALT
    for (int i = 0; i < 7; i++) begin
      clear_prog();
      prog[0] = {4'h6, 4'd1, vt[i].a};
      prog[1] = {4'h6, 4'd2, vt[i].b};
      prog[2] = (vt[i].op == OP_ADDI) ? {OP_ADDI, 4'd3, 4'd1, vt[i].b[3:0]}
                                      : {vt[i].op, 4'd3, 4'd1, 4'd2};
      prog[3] = 16'h6480;
      prog[4] = 16'h8340;
      sb.push_back({8'h80, vt[i].exp});
      run(0, 200, cyc);
      check({vt[i].name, " halted"}, 32'(halted), 32'd1);
      compare_stores(vt[i].name);
      check({vt[i].name, " illegal"}, 32'(illegal), 32'(vt[i].ill));
    end

    // ST then LD through 0x20, copy to 0x21; unstalled then 3-cycle stalls
    clear_prog();
    prog[0] = 16'h61A5; prog[1] = 16'h6420; prog[2] = 16'h8140;
    prog[3] = 16'h7540; prog[4] = 16'h6621; prog[5] = 16'h8560;
    for (int s = 0; s <= 3; s += 3) begin
      sb.push_back({8'h20, 16'h00A5});
      sb.push_back({8'h21, 16'h00A5});
      run(s, 300, cyc);
      check((s == 0) ? "ldst cycles" : "ldst stalled cycles", 32'(cyc),
            (s == 0) ? 32'd27 : 32'd57);
      compare_stores("ldst");
    end

    // Counted loop with backward BEQ, forward BEQ exit, JMP skip, SUB underflow
    clear_prog();
    prog[0]  = 16'h6103; prog[1]  = 16'h6201; prog[2]  = 16'h1112;
    prog[3]  = 16'h5331; prog[4]  = 16'h9101; prog[5]  = 16'h900C;
    prog[6]  = 16'hA008; prog[7]  = 16'h63EE; prog[8]  = 16'h1502;
    prog[9]  = 16'h6440; prog[10] = 16'h8340; prog[11] = 16'h5441;
    prog[12] = 16'h8540;
    sb.push_back({8'h40, 16'd3});
    sb.push_back({8'h41, 16'hFFFF});
    run(0, 500, cyc);
    check("loop halted", 32'(halted), 32'd1);
    compare_stores("loop");

    // Undefined opcode C, then ADDI still executes; illegal is sticky
    clear_prog();
    prog[0] = 16'hC000; prog[1] = 16'h5305; prog[2] = 16'h6450; prog[3] = 16'h8340;
    sb.push_back({8'h50, 16'd5});
    run(0, 200, cyc);
    compare_stores("illegal");
    check("illegal set", 32'(illegal), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("illegal sticky", 32'(illegal), 32'd1);
    check("halt no req",    32'(bus.mem_req), 32'd0);

    // Reset while the LD is waiting in MEM
    clear_prog();
    prog[0] = 16'h6420; prog[1] = 16'h7540;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    stall_n = 8;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 16'h0020) found = 1'b1;
    end
    check("mem access seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async drop req", 32'(bus.mem_req), 32'd0);
    check("async drop we",  32'(bus.mem_we),  32'd0);
    stall_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_req) found = 1'b1;
    end
    check("refetch seen", 32'(found), 32'd1);
    check("refetch addr", 32'(bus.mem_addr), 32'd0);
    check("refetch we",   32'(bus.mem_we),   32'd0);

    repeat (3) @(posedge clk);
    check("protocol", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
